// File: rtl/dm_access_arbiter.sv
// Shares the single-ported data memory between the pipeline MEM port (P) and a DMA port (D).
// Zero-cycle issue, 1-cycle read return; D is force-granted after STARVE_MAX denied cycles.
module dm_access_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_rw,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_stall,
  output logic [DW-1:0] p_rdata,
  output logic          p_rvalid,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {NORMAL, FORCE_D} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       rd_pend;
  logic       rd_owner;  // 0 = P, 1 = D
  logic       grant_p, grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      rd_pend    <= (grant_p & ~p_rw) | (grant_d & ~d_rw);
      if (grant_p | grant_d)
        rd_owner <= grant_d;
    end
  end

  always_comb begin
    grant_p        = 1'b0;
    grant_d        = 1'b0;
    starve_cnt_nxt = '0;
    state_nxt      = state;

    if (!reset) begin
      if (state == FORCE_D && d_req)
        grant_d = 1'b1;
      else if (p_req)
        grant_p = 1'b1;
      else if (d_req)
        grant_d = 1'b1;
    end

    if (d_req && !grant_d)
      starve_cnt_nxt = (starve_cnt >= CNT_MAX) ? CNT_MAX : starve_cnt + 4'd1;

    case (state)
      NORMAL:  if (starve_cnt_nxt == CNT_MAX) state_nxt = FORCE_D;
      FORCE_D: if (grant_d || !d_req)         state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    mem_en    = grant_p | grant_d;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_p) begin
      mem_rw    = p_rw;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (grant_d) begin
      mem_rw    = d_rw;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign p_stall = p_req & ~grant_p & ~reset;
  assign d_gnt   = grant_d;

  // A read issued just before reset must not surface while reset is held.
  assign p_rvalid = rd_pend & ~rd_owner & ~reset;
  assign d_rvalid = rd_pend &  rd_owner & ~reset;
  assign p_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Randomized bench for dm_access_arbiter against a denied-streak reference model and a memory model.
module tb_dm_access_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p_req = 1'b1, p_rw = 1'b0, d_req = 1'b1, d_rw = 1'b0;
  logic [AW-1:0] p_addr = '0, d_addr = '0;
  logic [DW-1:0] p_wdata = '0, d_wdata = '0;
  logic          p_stall, p_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] p_rdata, d_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  dm_access_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(N)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment: synchronous single-port memory driven by the DUT.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference state: memory image, consecutive denied-D cycles, outstanding read.
  logic [DW-1:0] ref_mem [0:255];
  int            streak = 0;
  int            pend_owner = 0;  // 0 none, 1 P, 2 D
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check current outputs against the model, then advance the model across the next edge.
  task automatic model_step();
    logic gp, gd, rw;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    gp = 1'b0; gd = 1'b0;
    if (!reset) begin
      if (streak >= N && d_req) gd = 1'b1;
      else if (p_req)           gp = 1'b1;
      else if (d_req)           gd = 1'b1;
    end
    rw = gp ? p_rw : (gd ? d_rw : 1'b0);
    a  = gp ? p_addr : (gd ? d_addr : '0);
    wd = gp ? p_wdata : (gd ? d_wdata : '0);

    chk("mem_en",    32'(mem_en),    32'(gp | gd));
    chk("mem_rw",    32'(mem_rw),    32'(rw));
    chk("mem_addr",  32'(mem_addr),  32'(a));
    chk("mem_wdata", 32'(mem_wdata), 32'(wd));
    chk("d_gnt",     32'(d_gnt),     32'(gd));
    chk("p_stall",   32'(p_stall),   32'(p_req & ~gp & ~reset));
    chk("p_rvalid",  32'(p_rvalid),  32'(!reset && pend_owner == 1));
    chk("d_rvalid",  32'(d_rvalid),  32'(!reset && pend_owner == 2));
    if (!reset && pend_owner == 1) chk("p_rdata", 32'(p_rdata), 32'(pend_data));
    if (!reset && pend_owner == 2) chk("d_rdata", 32'(d_rdata), 32'(pend_data));

    if (reset) begin
      streak = 0;
      pend_owner = 0;
    end else begin
      streak     = (d_req && !gd) ? streak + 1 : 0;
      pend_owner = ((gp | gd) && !rw) ? (gp ? 1 : 2) : 0;
      pend_data  = ref_mem[a[7:0]];
      if ((gp | gd) && rw) ref_mem[a[7:0]] = wd;
    end
  endtask

  task automatic cyc(input logic rst,
                     input logic preq, input logic prw, input logic [AW-1:0] pa, input logic [DW-1:0] pw,
                     input logic dreq, input logic drw, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    @(posedge clk);
    #1;
    reset = rst;
    p_req = preq; p_rw = prw; p_addr = pa; p_wdata = pw;
    d_req = dreq; d_rw = drw; d_addr = da; d_wdata = dw;
    @(negedge clk);
    model_step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset held with both requesters active.
    cyc(1, 1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    cyc(1, 1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
    chk("rst_p_stall", 32'(p_stall), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    cyc(0, 1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
    chk("post_rst_p_first", 32'(p_stall), 0);

    // P write then P read of the same word.
    cyc(0, 1, 1, 16'h0003, 16'hFFFF, 0, 0, 0, 0);
    chk("pw_addr", 32'(mem_addr), 32'h0003);
    chk("pw_wdata", 32'(mem_wdata), 32'hFFFF);
    cyc(0, 1, 0, 16'h0003, 0, 0, 0, 0, 0);
    chk("pw_no_rvalid", 32'(p_rvalid), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pr_rvalid", 32'(p_rvalid), 1);
    chk("pr_rdata", 32'(p_rdata), 32'hFFFF);

    // Sustained contention: D wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 16'(i), 0, 1, 0, 16'(16 + i), 0);
      chk("cont_d_gnt", 32'(d_gnt), 32'((i % (N + 1)) == N));
      chk("cont_p_stall", 32'(p_stall), 32'((i % (N + 1)) == N));
    end

    // D alone.
    cyc(0, 0, 0, 0, 0, 1, 0, 16'h0010, 0);
    chk("donly_gnt", 32'(d_gnt), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("donly_rvalid", 32'(d_rvalid), 1);

    // Reset immediately after a granted P read.
    cyc(0, 1, 0, 16'h0003, 0, 1, 0, 16'h0004, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstrd_rvalid_k1", 32'(p_rvalid), 0);
    cyc(0, 1, 0, 16'h0005, 0, 1, 0, 16'h0006, 0);
    chk("rstrd_rvalid_k2", 32'(p_rvalid), 0);
    chk("rstrd_normal", 32'(d_gnt), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 7), 1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom),
          ($urandom_range(0, 9) < 6), 1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
